// File: rtl/flag_hs_pkg.sv
// flag_hs_pkg
// Shared constants and helpers for the toggle-handshake responder.
//   SYNC_STAGES_MIN : smallest usable synchronizer depth
//   PEND_W_DEFAULT  : default pending-counter width
//   DROP_CNT_W      : width of the optional dropped-event counter
//   pend_max()      : largest count a PEND_W-bit pending counter holds
package flag_hs_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned PEND_W_DEFAULT  = 4;
    localparam int unsigned DROP_CNT_W      = 8;

    function automatic int unsigned pend_max(input int unsigned pend_w);
        return (32'd1 << pend_w) - 32'd1;
    endfunction

endpackage

// File: rtl/flag_sync_edge.sv
// flag_sync_edge
// Synchronises the remote request toggle, keeps a history flop of the
// last synchronised level and flags each level change as a one-cycle pulse.
// Ports:
//   clk              : block clock
//   rst              : synchronous active-high reset
//   req_toggle_async : remote toggle, one event per level change
//   evt_edge         : one-cycle pulse per synchronised transition
//   in_flight        : a transition is somewhere in the chain, not yet absorbed by hist
// Parameter SYNC_STAGES must be at least 2.
module flag_sync_edge
    import flag_hs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic req_toggle_async,
    output logic evt_edge,
    output logic in_flight
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic [SYNC_STAGES-1:0] diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], req_toggle_async};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Any stage disagreeing with hist means a transition has entered the
    // chain but has not yet been counted.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_diff
        assign diff[gi] = sync_reg[gi] ^ hist_reg;
    end

    assign evt_edge  = diff[SYNC_STAGES-1];
    assign in_flight = |diff;

endmodule

// File: rtl/flag_handshake_responder.sv
// flag_handshake_responder
// Receive side of a two-phase toggle handshake. Remote events arrive as
// level changes on req_toggle_async, are counted in a saturating pending
// counter and offered to a local consumer over valid/ready. Every consumed
// event flips ack_toggle back to the remote side.
// Ports:
//   clk, rst         : block clock, synchronous active-high reset
//   req_toggle_async : remote event toggle
//   evt_valid        : at least one event pending
//   evt_ready        : consumer takes the presented event
//   ack_toggle       : flips once per consumed event
//   pending          : number of unconsumed events
//   overflow         : sticky, an event was dropped while full
//   busy             : events pending or a transition still synchronising
//   drop_cnt         : saturating dropped-event count (FLAG_HS_DROP_CNT_EN only)
// Optional feature macro: FLAG_HS_DROP_CNT_EN
module flag_handshake_responder
    import flag_hs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PEND_W      = PEND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_toggle_async,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              ack_toggle,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
`ifdef FLAG_HS_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic              busy
);

    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(pend_max(PEND_W));

    logic              evt_edge;
    logic              in_flight;
    logic              accept;
    logic [PEND_W-1:0] pending_reg;
    logic              ack_reg;
    logic              overflow_reg;
`ifdef FLAG_HS_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
`endif

    flag_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk              (clk),
        .rst              (rst),
        .req_toggle_async (req_toggle_async),
        .evt_edge         (evt_edge),
        .in_flight        (in_flight)
    );

    assign evt_valid = (pending_reg != '0);
    assign accept    = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg  <= '0;
            ack_reg      <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef FLAG_HS_DROP_CNT_EN
            drop_cnt_reg <= '0;
`endif
        end else begin
            if (accept) begin
                ack_reg <= ~ack_reg;
            end
            // A simultaneous arrival and accept cancel out, so a full counter
            // only drops an event when nothing is being consumed.
            if (evt_edge && !accept) begin
                if (pending_reg == PEND_FULL) begin
                    overflow_reg <= 1'b1;
`ifdef FLAG_HS_DROP_CNT_EN
                    if (drop_cnt_reg != {DROP_CNT_W{1'b1}}) begin
                        drop_cnt_reg <= drop_cnt_reg + 1'b1;
                    end
`endif
                end else begin
                    pending_reg <= pending_reg + 1'b1;
                end
            end else if (accept && !evt_edge) begin
                pending_reg <= pending_reg - 1'b1;
            end
        end
    end

    assign ack_toggle = ack_reg;
    assign pending    = pending_reg;
    assign overflow   = overflow_reg;
    assign busy       = evt_valid | in_flight;
`ifdef FLAG_HS_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_flag_handshake_responder.sv
// tb_flag_handshake_responder
// Directed scenarios for flag_handshake_responder. Stimulus pushes the
// expected ack_toggle value for every event that should be consumed; a
// separate monitor pops one entry per observed accept and checks ack_toggle
// after the edge. Level checks (pending, valid, overflow, busy) are made
// directly in the stimulus thread, 2 time units after the clock edge.
module tb_flag_handshake_responder;

    localparam int PEND_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_toggle_async = 1'b0;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic              ack_toggle;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic              busy;
`ifdef FLAG_HS_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic exp_ack = 1'b0;
    logic ack_q[$];

    always #5 clk = ~clk;

    flag_handshake_responder #(
        .SYNC_STAGES (2),
        .PEND_W      (PEND_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_toggle_async (req_toggle_async),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .ack_toggle       (ack_toggle),
        .pending          (pending),
        .overflow         (overflow),
`ifdef FLAG_HS_DROP_CNT_EN
        .drop_cnt         (drop_cnt),
`endif
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Flip the request; if the event should be consumed, queue the ack
    // level expected after its accept.
    task automatic send(input bit expect_accept, input int gap);
        req_toggle_async = ~req_toggle_async;
        if (expect_accept) begin
            exp_ack = ~exp_ack;
            ack_q.push_back(exp_ack);
        end
        tick(gap);
    endtask

    task automatic do_reset(input logic req_level);
        rst = 1'b1;
        req_toggle_async = req_level;
        evt_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        ack_q.delete();
        exp_ack = 1'b0;
    endtask

    // Scoreboard monitor: one pop per accept, ack checked after the edge.
    always begin
        @(negedge clk);
        if (!rst && evt_valid && evt_ready) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_accept", 32'd1, 32'd0);
            end else begin
                logic want;
                want = ack_q.pop_front();
                @(posedge clk);
                #1;
                chk("sb_ack_toggle", 32'(ack_toggle), 32'(want));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset(1'b0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack_toggle), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // Single event with ready held high: 3 edges to valid, 1-cycle pulse
        evt_ready = 1'b1;
        send(1'b1, 1);
        chk("s1_valid_e1", 32'(evt_valid), 32'd0);
        tick(1);
        chk("s1_valid_e2", 32'(evt_valid), 32'd0);
        chk("s1_busy_e2", 32'(busy), 32'd1);
        tick(1);
        chk("s1_valid_e3", 32'(evt_valid), 32'd1);
        chk("s1_pending_e3", 32'(pending), 32'd1);
        tick(1);
        chk("s1_valid_e4", 32'(evt_valid), 32'd0);
        chk("s1_pending_e4", 32'(pending), 32'd0);
        chk("s1_ack_e4", 32'(ack_toggle), 32'd1);
        chk("s1_busy_e4", 32'(busy), 32'd0);
        evt_ready = 1'b0;
        tick(2);
        chk("s1_sb_empty", 32'(ack_q.size()), 32'd0);

        // Five queued events, then five back-to-back accepts
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 4);
        chk("s2_pending5", 32'(pending), 32'd5);
        chk("s2_valid", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        tick(5);
        evt_ready = 1'b0;
        chk("s2_pending0", 32'(pending), 32'd0);
        chk("s2_ack_odd", 32'(ack_toggle), 32'd1);
        chk("s2_valid0", 32'(evt_valid), 32'd0);
        tick(2);
        chk("s2_sb_empty", 32'(ack_q.size()), 32'd0);

        // Fill to 15, two more are dropped
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) send(1'b1, 4);
        chk("s3_pending_full", 32'(pending), 32'd15);
        chk("s3_overflow_clear", 32'(overflow), 32'd0);
        send(1'b0, 4);
        send(1'b0, 4);
        chk("s3_pending_hold", 32'(pending), 32'd15);
        chk("s3_overflow_set", 32'(overflow), 32'd1);
`ifdef FLAG_HS_DROP_CNT_EN
        chk("s3_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        evt_ready = 1'b1;
        tick(15);
        evt_ready = 1'b0;
        chk("s3_drained", 32'(pending), 32'd0);
        chk("s3_ack", 32'(ack_toggle), 32'd1);
        chk("s3_overflow_sticky", 32'(overflow), 32'd1);
        tick(2);
        chk("s3_sb_empty", 32'(ack_q.size()), 32'd0);

        // Full counter, accept coincides with the edge: nothing dropped
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) send(1'b1, 4);
        send(1'b1, 2);              // edge is high now
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("s4_pending", 32'(pending), 32'd15);
        chk("s4_overflow", 32'(overflow), 32'd0);
        chk("s4_ack", 32'(ack_toggle), 32'd1);
        evt_ready = 1'b1;
        tick(15);
        evt_ready = 1'b0;
        chk("s4_drained", 32'(pending), 32'd0);
        chk("s4_ack_even", 32'(ack_toggle), 32'd0);
        tick(2);
        chk("s4_sb_empty", 32'(ack_q.size()), 32'd0);

        // Mid-stream reset discards pending events
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 4);
        chk("s5_pending3", 32'(pending), 32'd3);
        rst = 1'b1;
        req_toggle_async = 1'b0;
        tick(1);
        rst = 1'b0;
        ack_q.delete();
        exp_ack = 1'b0;
        chk("s5_pending0", 32'(pending), 32'd0);
        chk("s5_valid0", 32'(evt_valid), 32'd0);
        chk("s5_ack0", 32'(ack_toggle), 32'd0);
        chk("s5_overflow0", 32'(overflow), 32'd0);
        tick(4);
        chk("s5_no_spurious", 32'(pending), 32'd0);
        send(1'b1, 4);
        chk("s5_single", 32'(pending), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("s5_consumed", 32'(pending), 32'd0);
        chk("s5_ack1", 32'(ack_toggle), 32'd1);

        // Request already high at reset release: exactly one event
        do_reset(1'b1);
        exp_ack = 1'b1;
        ack_q.push_back(1'b1);
        tick(6);
        chk("s6_pending1", 32'(pending), 32'd1);
        tick(10);
        chk("s6_still1", 32'(pending), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("s6_pending0", 32'(pending), 32'd0);
        chk("s6_ack1", 32'(ack_toggle), 32'd1);
        tick(5);
        chk("s6_no_more", 32'(pending), 32'd0);
        chk("s6_busy0", 32'(busy), 32'd0);
        chk("s6_sb_empty", 32'(ack_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
